frame_sequencer: RTL and testbench

Frame-level controller for the three-pixels-per-clock image datapath. It accepts a frame start request and latches the operation select. It then sequences vertical blanking, per-line horizontal blanking and active data. It drives the row/column/pixel-address counters that the processing datapath indexes with. Downstream back-pressure, abort and end-of-frame signalling are handled here so the datapath itself stays purely combinational.

---
 rtl/frame_sequencer.sv | 140 ++++++++++++++
 tb/tb_frame_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Frame-level sequencer: vertical blank, per-line horizontal blank and active data with row/col/pix_addr counters.
// Define CONTINUOUS_MODE_EN to make frames repeat back-to-back until abort.
module frame_sequencer #(
    parameter int IM_WIDTH    = 768,
    parameter int IM_HEIGHT   = 512,
    parameter int PIX_PER_CLK = 3,
    parameter int VSYNC_DELAY = 100,
    parameter int HSYNC_DELAY = 160
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        start_req,
    input  logic [1:0]  op_sel,
    input  logic        abort,
    input  logic        ds_ready,
    output logic        busy,
    output logic [1:0]  op_active,
    output logic        Vsync,
    output logic        Hsync,
    output logic [9:0]  row,
    output logic [10:0] col,
    output logic [18:0] pix_addr,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_HSYNC,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [10:0] LAST_COL = 11'(IM_WIDTH - PIX_PER_CLK);
    localparam logic [9:0]  LAST_ROW = 10'(IM_HEIGHT - 1);
    localparam logic [10:0] COL_STEP = 11'(PIX_PER_CLK);
    localparam logic [18:0] PIX_STEP = 19'(PIX_PER_CLK);
    localparam logic [8:0]  VS_LAST  = 9'(VSYNC_DELAY);
    localparam logic [8:0]  HS_LAST  = 9'(HSYNC_DELAY);

    state_t      r_state;
    logic [8:0]  r_blank;
    logic [1:0]  r_op;
    logic [9:0]  r_row;
    logic [10:0] r_col;
    logic [18:0] r_pix;

    logic w_line_end;
    logic w_last_line;

    assign w_line_end  = (r_col == LAST_COL);
    assign w_last_line = (r_row == LAST_ROW);

    // Abort outranks every other transition and leaves op_active untouched.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_blank <= '0;
            r_op    <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_pix   <= '0;
        end else if (abort && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            r_blank <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_pix   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_req) begin
                        r_op    <= op_sel;
                        r_blank <= '0;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_pix   <= '0;
                        r_state <= S_VSYNC;
                    end
                end
                S_VSYNC: begin
                    if (r_blank == VS_LAST) begin
                        r_blank <= '0;
                        r_state <= S_HSYNC;
                    end else begin
                        r_blank <= r_blank + 9'd1;
                    end
                end
                S_HSYNC: begin
                    if (r_blank == HS_LAST) begin
                        r_blank <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_blank <= r_blank + 9'd1;
                    end
                end
                S_DATA: begin
                    // Without ds_ready the same pixel group is simply re-presented.
                    if (ds_ready) begin
                        r_pix <= r_pix + PIX_STEP;
                        if (w_line_end) begin
                            r_col <= '0;
                            if (w_last_line) begin
                                r_state <= S_DONE;
                            end else begin
                                r_row   <= r_row + 10'd1;
                                r_state <= S_HSYNC;
                            end
                        end else begin
                            r_col <= r_col + COL_STEP;
                        end
                    end
                end
                S_DONE: begin
`ifdef CONTINUOUS_MODE_EN
                    r_op    <= op_sel;
                    r_blank <= '0;
                    r_row   <= '0;
                    r_col   <= '0;
                    r_pix   <= '0;
                    r_state <= S_VSYNC;
`else
                    r_state <= S_IDLE;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign Vsync      = (r_state == S_VSYNC);
    assign Hsync      = (r_state == S_DATA);
    assign frame_done = (r_state == S_DONE);
    assign op_active  = r_op;
    assign row        = r_row;
    assign col        = r_col;
    assign pix_addr   = r_pix;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: stimulus queues expected data beats, frame_done cycles
// and Vsync run lengths; a negedge monitor pops and compares whenever the DUT presents them.
module tb_frame_sequencer;

    localparam int W   = 6;
    localparam int H   = 2;
    localparam int PPC = 3;
    localparam int VD  = 3;
    localparam int HD  = 2;

    logic        clk = 1'b0;
    logic        Reset;
    logic        start_req;
    logic [1:0]  op_sel;
    logic        abort;
    logic        ds_ready;
    logic        busy;
    logic [1:0]  op_active;
    logic        Vsync;
    logic        Hsync;
    logic [9:0]  row;
    logic [10:0] col;
    logic [18:0] pix_addr;
    logic        frame_done;

    frame_sequencer #(
        .IM_WIDTH(W), .IM_HEIGHT(H), .PIX_PER_CLK(PPC),
        .VSYNC_DELAY(VD), .HSYNC_DELAY(HD)
    ) dut (
        .clk(clk), .Reset(Reset), .start_req(start_req), .op_sel(op_sel),
        .abort(abort), .ds_ready(ds_ready), .busy(busy), .op_active(op_active),
        .Vsync(Vsync), .Hsync(Hsync), .row(row), .col(col), .pix_addr(pix_addr),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int row;
        int col;
        int pix;
        int op;
    } beat_t;

    beat_t beatQ[$];
    int    doneQ[$];
    int    vsQ[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    int    accNeg = 0;
    int    vsRun  = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Cycle n after acceptance is the period that follows acceptance edge + (n-1).
    always @(negedge clk) begin
        beat_t b;
        int    d;
        int    v;
        cyc++;
        if (Hsync) begin
            if (beatQ.size() == 0) begin
                checkOutput("unexpected_beat_cycle", cyc - accNeg, -1);
            end else begin
                b = beatQ.pop_front();
                checkOutput("beat_cycle", cyc - accNeg, b.cyc);
                checkOutput("beat_row", int'(row), b.row);
                checkOutput("beat_col", int'(col), b.col);
                checkOutput("beat_pix_addr", int'(pix_addr), b.pix);
                checkOutput("beat_op_active", int'(op_active), b.op);
            end
        end
        if (frame_done) begin
            if (doneQ.size() == 0) begin
                checkOutput("unexpected_done_cycle", cyc - accNeg, -1);
            end else begin
                d = doneQ.pop_front();
                checkOutput("done_cycle", cyc - accNeg, d);
            end
        end
        if (Vsync) begin
            vsRun++;
        end else if (vsRun > 0) begin
            if (vsQ.size() == 0) begin
                checkOutput("unexpected_vsync_run", vsRun, -1);
            end else begin
                v = vsQ.pop_front();
                checkOutput("vsync_run_len", vsRun, v);
            end
            vsRun = 0;
        end
    end

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] op);
        @(posedge clk);
        #1;
        start_req = 1'b1;
        op_sel    = op;
        @(posedge clk);
        #1;
        start_req = 1'b0;
        accNeg    = cyc;
    endtask

    task automatic pushBeat(input int c, input int r, input int cl, input int p, input int op);
        beat_t b;
        b.cyc = c; b.row = r; b.col = cl; b.pix = p; b.op = op;
        beatQ.push_back(b);
    endtask

    task automatic pushPlainFrame(input int base, input int op);
        pushBeat(base + 8,  0, 0, 0, op);
        pushBeat(base + 9,  0, 3, 3, op);
        pushBeat(base + 13, 1, 0, 6, op);
        pushBeat(base + 14, 1, 3, 9, op);
        doneQ.push_back(base + 15);
        vsQ.push_back(VD + 1);
    endtask

    task automatic checkDrained(input string tag);
        checkOutput({tag, "_beats_left"}, beatQ.size(), 0);
        checkOutput({tag, "_done_left"}, doneQ.size(), 0);
        checkOutput({tag, "_vsync_left"}, vsQ.size(), 0);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_vsync"}, int'(Vsync), 0);
        checkOutput({tag, "_hsync"}, int'(Hsync), 0);
        checkOutput({tag, "_frame_done"}, int'(frame_done), 0);
        checkOutput({tag, "_row"}, int'(row), 0);
        checkOutput({tag, "_col"}, int'(col), 0);
        checkOutput({tag, "_pix_addr"}, int'(pix_addr), 0);
    endtask

    initial begin
        Reset     = 1'b1;
        start_req = 1'b0;
        op_sel    = 2'd0;
        abort     = 1'b0;
        ds_ready  = 1'b1;
        #12;
        checkIdle("reset");
        checkOutput("reset_op_active", int'(op_active), 0);
        @(posedge clk);
        #1;
        Reset = 1'b0;
        waitEdges(2);

`ifdef CONTINUOUS_MODE_EN
        $display("[TB] continuous frames with relatched op_sel, then abort");
        applyStimulus(2'd2);
        op_sel = 2'd3;
        pushPlainFrame(0, 2);
        pushPlainFrame(15, 3);
        vsQ.pop_back();
        vsQ.push_back(VD + 1);
        vsQ.push_back(2);
        waitEdges(31);
        abort = 1'b1;
        waitEdges(1);
        abort = 1'b0;
        checkIdle("cont_abort");
        waitEdges(5);
        checkDrained("cont");
`else
        $display("[TB] plain frame, op_sel=2");
        applyStimulus(2'd2);
        pushPlainFrame(0, 2);
        waitEdges(20);
        checkDrained("plain");
        checkOutput("plain_busy_after", int'(busy), 0);

        $display("[TB] frame with two-cycle ds_ready stall at row 0 col 3");
        applyStimulus(2'd2);
        pushBeat(8,  0, 0, 0, 2);
        pushBeat(9,  0, 3, 3, 2);
        pushBeat(10, 0, 3, 3, 2);
        pushBeat(11, 0, 3, 3, 2);
        pushBeat(15, 1, 0, 6, 2);
        pushBeat(16, 1, 3, 9, 2);
        doneQ.push_back(17);
        vsQ.push_back(VD + 1);
        waitEdges(8);
        ds_ready = 1'b0;
        waitEdges(2);
        ds_ready = 1'b1;
        waitEdges(12);
        checkDrained("stall");

        $display("[TB] abort during second HSYNC");
        applyStimulus(2'd2);
        pushBeat(8, 0, 0, 0, 2);
        pushBeat(9, 0, 3, 3, 2);
        vsQ.push_back(VD + 1);
        waitEdges(10);
        abort = 1'b1;
        waitEdges(1);
        abort = 1'b0;
        checkIdle("abort");
        waitEdges(10);
        checkDrained("abort");

        $display("[TB] start_req and op_sel change ignored mid-frame");
        applyStimulus(2'd2);
        op_sel = 2'd1;
        pushPlainFrame(0, 2);
        waitEdges(7);
        start_req = 1'b1;
        waitEdges(1);
        start_req = 1'b0;
        waitEdges(12);
        checkDrained("ignore");
        checkOutput("ignore_op_active", int'(op_active), 2);
        checkOutput("ignore_busy_after", int'(busy), 0);

        $display("[TB] asynchronous reset mid-DATA");
        applyStimulus(2'd2);
        pushBeat(8, 0, 0, 0, 2);
        vsQ.push_back(VD + 1);
        waitEdges(8);
        Reset = 1'b1;
        #1;
        checkIdle("async_reset");
        checkOutput("async_reset_op_active", int'(op_active), 0);
        waitEdges(1);
        Reset = 1'b0;
        waitEdges(10);
        checkDrained("async_reset");
        checkOutput("post_reset_busy", int'(busy), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
